cog_accumulator_param: RTL and testbench
========================================

// Module: cog_accumulator_param
// PURPOSE
//  Parametrised centre-of-gravity accumulator for 1-D pixel figures on a line.
//  Sits between figure segmentation and the CoG transmitter. Per figure it produces sum(w), sum(w*idx),
//  pixel count, start coordinate and a validity verdict; w is selectable as I, I^2 or (I-bg)^2 clamped at 0.
//  Successor of the fixed 8-bit/I^2 CoG stage: runtime limits, weight modes, result handshake, error flags.
// PARAMETERS
//  DATA_WIDTH   8    pixel intensity width
//  COORD_WIDTH  11   start-point coordinate width; also pixel-index/counter width
//  SB_WIDTH     3    sideband bits delayed in lockstep (eol, eof, new_frame)
// PORTS
//  i_sys_clk         in   1                clock
//  i_sys_reset       in   1                synchronous, active-high reset
//  i_data_image      in   DATA_WIDTH       pixel intensity
//  i_data_valid      in   1                pixel qualifier
//  i_start_of_fig    in   1                first pixel of figure (qualified by i_data_valid)
//  i_end_of_fig      in   1                last pixel of figure (qualified by i_data_valid)
//  i_start_point     in   COORD_WIDTH      coordinate of first pixel, sampled with i_start_of_fig
//  i_weight_mode     in   2                0=I, 1=I^2, 2=(I-bg)^2 clamp 0, 3=reserved (acts as 1)
//  i_bg_level        in   DATA_WIDTH       background level for mode 2
//  i_min_pixels      in   COORD_WIDTH      smallest accepted count (inclusive)
//  i_max_pixels      in   COORD_WIDTH      largest accepted count (inclusive)
//  o_res_valid       out  1                result held; cleared by o_res_valid & i_res_ready
//  i_res_ready       in   1                consumer ready
//  o_sum_w           out  2*DATA_WIDTH+COORD_WIDTH    sum of weights
//  o_sum_w_idx       out  2*DATA_WIDTH+2*COORD_WIDTH  sum of weight*index
//  o_pixel_count     out  COORD_WIDTH      pixels in figure (saturating)
//  o_start_point     out  COORD_WIDTH      start coordinate of this figure
//  o_point_ok        out  1                min<=count<=max and counter not saturated
//  o_overrun         out  1                sticky: result dropped because holding reg was full
//  o_abort           out  1                sticky: start_of_fig seen while figure open
//  i_sideband        in   SB_WIDTH         eol/eof/new_frame to be delayed
//  o_sideband        out  SB_WIDTH         i_sideband delayed exactly 3 cycles
// BEHAVIOUR
//  - Reset: all outputs 0; accumulators, counter, pipeline valids and sideband delay line cleared; FSM -> IDLE.
//  - FSM IDLE -> IN_FIG on valid&start_of_fig (unless end_of_fig same cycle: 1-pixel figure, stays IDLE).
//    IN_FIG -> IDLE on valid&end_of_fig. Valid pixels in IDLE without start are ignored.
//  - Pipeline: S1 weight + index (idx 0 for first pixel, +1 per valid pixel); S2 w*idx; S3 accumulate.
//    The first pixel of a figure loads the accumulators (no clear bubble); back-to-back figures allowed.
//  - Latency: o_res_valid rises 3 cycles after the valid&end_of_fig cycle when the holding reg is empty.
//  - Handshake: the result is held stable while o_res_valid & ~i_res_ready. A new result arriving
//    while full is dropped, the held one kept, o_overrun set. Accept and new arrival in the same
//    cycle: load new result, no overrun.
//  - Counter saturates at 2^COORD_WIDTH-1; saturation forces o_point_ok=0; sums do not overflow at saturation.
//  - Weight: mode 0 zero-extended I; mode 1 I*I; mode 2 (I>bg ? (I-bg)^2 : 0). Mode, bg and limits are
//    sampled at start_of_fig and held for the whole figure.
//  - start_of_fig in IN_FIG: open figure discarded (no result), o_abort set, new figure begins with idx 0.
//  - o_overrun/o_abort cleared only by reset. Sideband delay is independent of the handshake.
// STRUCTURE
//  - cog_pkg: weight_mode_t enum, fig_state_t enum, width localparams/functions (sum widths, LAT=3).
//  - Sub-module cog_delay_line #(WIDTH, DEPTH): shift register used for o_sideband.
// TESTING
//  1 mode1, start_point=57, pixels 10,20,30 -> sum_w=1400, sum_w_idx=2200, count=3, ok=1, sp=57, 3-cycle latency.
//  2 mode0 same pixels -> sum_w=60, sum_w_idx=80; mode2 bg=15 -> sum_w=250, sum_w_idx=475.
//  3 min=3,max=100: 2-pixel and 101-pixel figures -> ok=0; 1-pixel fig (start&end together) -> count=1, ok=0.
//  4 i_res_ready=0, two back-to-back figures -> first held unchanged, o_overrun=1; ready=1 then -> accepted.
//  5 start_of_fig mid-figure -> o_abort=1, only second figure reported; sideband pulse emerges 3 cycles later.
//  6 reset asserted mid-figure -> all outputs 0, next clean figure yields correct sums.

Source files
------------

// File: rtl/cog_pkg.sv
// Shared types and width helpers for the centre-of-gravity accumulator.
package cog_pkg;

  typedef enum logic [1:0] {
    WM_LIN = 2'd0,
    WM_SQ  = 2'd1,
    WM_BG  = 2'd2,
    WM_RSV = 2'd3
  } weight_mode_t;

  typedef enum logic {
    FIG_IDLE = 1'b0,
    FIG_OPEN = 1'b1
  } fig_state_t;

  // Pixel-to-result latency; the sideband delay line uses the same depth.
  localparam int unsigned LAT = 3;

  function automatic int unsigned weight_width(input int unsigned dw);
    return 2 * dw;
  endfunction

  function automatic int unsigned sum_w_width(input int unsigned dw, input int unsigned cw);
    return 2 * dw + cw;
  endfunction

  function automatic int unsigned sum_wi_width(input int unsigned dw, input int unsigned cw);
    return 2 * dw + 2 * cw;
  endfunction

endpackage

// File: rtl/cog_delay_line.sv
// Fixed-depth shift register with synchronous clear.
module cog_delay_line #(
  parameter int unsigned WIDTH = 3,
  parameter int unsigned DEPTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else begin
      stage[0] <= din;
      for (int unsigned i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign dout = stage[DEPTH-1];

endmodule

// File: rtl/cog_accumulator_param.sv
// Per-figure weighted sum / weighted-index accumulator with result handshake.
module cog_accumulator_param
  import cog_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned COORD_WIDTH = 11,
  parameter int unsigned SB_WIDTH    = 3
) (
  input  logic                                 i_sys_clk,
  input  logic                                 i_sys_reset,
  input  logic [DATA_WIDTH-1:0]                i_data_image,
  input  logic                                 i_data_valid,
  input  logic                                 i_start_of_fig,
  input  logic                                 i_end_of_fig,
  input  logic [COORD_WIDTH-1:0]               i_start_point,
  input  logic [1:0]                           i_weight_mode,
  input  logic [DATA_WIDTH-1:0]                i_bg_level,
  input  logic [COORD_WIDTH-1:0]               i_min_pixels,
  input  logic [COORD_WIDTH-1:0]               i_max_pixels,
  output logic                                 o_res_valid,
  input  logic                                 i_res_ready,
  output logic [2*DATA_WIDTH+COORD_WIDTH-1:0]   o_sum_w,
  output logic [2*DATA_WIDTH+2*COORD_WIDTH-1:0] o_sum_w_idx,
  output logic [COORD_WIDTH-1:0]               o_pixel_count,
  output logic [COORD_WIDTH-1:0]               o_start_point,
  output logic                                 o_point_ok,
  output logic                                 o_overrun,
  output logic                                 o_abort,
  input  logic [SB_WIDTH-1:0]                  i_sideband,
  output logic [SB_WIDTH-1:0]                  o_sideband
);

  localparam int unsigned WW  = weight_width(DATA_WIDTH);
  localparam int unsigned SW  = sum_w_width(DATA_WIDTH, COORD_WIDTH);
  localparam int unsigned SWI = sum_wi_width(DATA_WIDTH, COORD_WIDTH);
  localparam int unsigned PW  = WW + COORD_WIDTH;
  localparam logic [COORD_WIDTH-1:0] CNT_MAX = '1;

  fig_state_t state, state_nxt;
  logic first_c, accept_c, last_c, abort_c;

  weight_mode_t           fig_mode, mode_e;
  logic [DATA_WIDTH-1:0]  fig_bg, bg_e, diff;
  logic [COORD_WIDTH-1:0] fig_min, fig_max, fig_sp, fig_cnt;
  logic [COORD_WIDTH-1:0] min_e, max_e, sp_e, cnt_e, cnt_new;
  logic                   fig_sat, sat_e, sat_hit, sat_new, ok_new;
  logic [WW-1:0]          w_c;

  logic                   s1_valid, s1_first, s1_last, s1_ok;
  logic [WW-1:0]          s1_w;
  logic [COORD_WIDTH-1:0] s1_idx, s1_cnt, s1_sp;
  logic                   s2_valid, s2_first, s2_last, s2_ok;
  logic [WW-1:0]          s2_w;
  logic [PW-1:0]          s2_wi;
  logic [COORD_WIDTH-1:0] s2_cnt, s2_sp;
  logic [SW-1:0]          acc_w, acc_w_nxt;
  logic [SWI-1:0]         acc_wi, acc_wi_nxt;

  always_ff @(posedge i_sys_clk) begin
    if (i_sys_reset) state <= FIG_IDLE;
    else             state <= state_nxt;
  end

  // A start while a figure is open restarts the figure and flags the abort.
  always_comb begin
    state_nxt = state;
    first_c   = i_data_valid & i_start_of_fig;
    accept_c  = first_c | (i_data_valid & (state == FIG_OPEN));
    last_c    = accept_c & i_end_of_fig;
    abort_c   = first_c & (state == FIG_OPEN);
    if (accept_c) state_nxt = last_c ? FIG_IDLE : FIG_OPEN;
  end

  // Figure context comes straight from the inputs on the first pixel, else from the held copy.
  always_comb begin
    mode_e = fig_mode;
    bg_e   = fig_bg;
    min_e  = fig_min;
    max_e  = fig_max;
    sp_e   = fig_sp;
    cnt_e  = fig_cnt;
    sat_e  = fig_sat;
    if (first_c) begin
      mode_e = weight_mode_t'(i_weight_mode);
      bg_e   = i_bg_level;
      min_e  = i_min_pixels;
      max_e  = i_max_pixels;
      sp_e   = i_start_point;
      cnt_e  = '0;
      sat_e  = 1'b0;
    end
    sat_hit = (cnt_e == CNT_MAX);
    cnt_new = sat_hit ? CNT_MAX : cnt_e + COORD_WIDTH'(1);
    sat_new = sat_e | sat_hit;
    ok_new  = ~sat_new & (cnt_new >= min_e) & (cnt_new <= max_e);
    diff    = i_data_image - bg_e;
    w_c     = '0;
    // Pixels past counter saturation contribute nothing, so the sums cannot overflow.
    if (!sat_hit) begin
      case (mode_e)
        WM_LIN:  w_c = WW'(i_data_image);
        WM_BG:   if (i_data_image > bg_e) w_c = WW'(diff) * WW'(diff);
        default: w_c = WW'(i_data_image) * WW'(i_data_image);
      endcase
    end
  end

  always_comb begin
    acc_w_nxt  = s2_first ? SW'(s2_w)   : acc_w  + SW'(s2_w);
    acc_wi_nxt = s2_first ? SWI'(s2_wi) : acc_wi + SWI'(s2_wi);
  end

  always_ff @(posedge i_sys_clk) begin
    if (i_sys_reset) begin
      fig_mode <= WM_LIN;
      fig_bg   <= '0;
      fig_min  <= '0;
      fig_max  <= '0;
      fig_sp   <= '0;
      fig_cnt  <= '0;
      fig_sat  <= 1'b0;
      s1_valid <= 1'b0;
      s1_first <= 1'b0;
      s1_last  <= 1'b0;
      s1_ok    <= 1'b0;
      s1_w     <= '0;
      s1_idx   <= '0;
      s1_cnt   <= '0;
      s1_sp    <= '0;
      s2_valid <= 1'b0;
      s2_first <= 1'b0;
      s2_last  <= 1'b0;
      s2_ok    <= 1'b0;
      s2_w     <= '0;
      s2_wi    <= '0;
      s2_cnt   <= '0;
      s2_sp    <= '0;
      acc_w    <= '0;
      acc_wi   <= '0;
    end else begin
      if (accept_c) begin
        fig_mode <= mode_e;
        fig_bg   <= bg_e;
        fig_min  <= min_e;
        fig_max  <= max_e;
        fig_sp   <= sp_e;
        fig_cnt  <= cnt_new;
        fig_sat  <= sat_new;
      end
      s1_valid <= accept_c;
      s1_first <= first_c;
      s1_last  <= last_c;
      s1_ok    <= ok_new;
      s1_w     <= w_c;
      s1_idx   <= cnt_e;
      s1_cnt   <= cnt_new;
      s1_sp    <= sp_e;
      s2_valid <= s1_valid;
      s2_first <= s1_first;
      s2_last  <= s1_last;
      s2_ok    <= s1_ok;
      s2_w     <= s1_w;
      s2_wi    <= PW'(s1_w) * PW'(s1_idx);
      s2_cnt   <= s1_cnt;
      s2_sp    <= s1_sp;
      if (s2_valid) begin
        acc_w  <= acc_w_nxt;
        acc_wi <= acc_wi_nxt;
      end
    end
  end

  // Holding register: a same-cycle accept frees the slot for the arriving result.
  always_ff @(posedge i_sys_clk) begin
    if (i_sys_reset) begin
      o_res_valid   <= 1'b0;
      o_sum_w       <= '0;
      o_sum_w_idx   <= '0;
      o_pixel_count <= '0;
      o_start_point <= '0;
      o_point_ok    <= 1'b0;
      o_overrun     <= 1'b0;
      o_abort       <= 1'b0;
    end else begin
      if (s2_valid && s2_last) begin
        if (!o_res_valid || i_res_ready) begin
          o_res_valid   <= 1'b1;
          o_sum_w       <= acc_w_nxt;
          o_sum_w_idx   <= acc_wi_nxt;
          o_pixel_count <= s2_cnt;
          o_start_point <= s2_sp;
          o_point_ok    <= s2_ok;
        end else begin
          o_overrun <= 1'b1;
        end
      end else if (o_res_valid && i_res_ready) begin
        o_res_valid <= 1'b0;
      end
      if (abort_c) o_abort <= 1'b1;
    end
  end

  cog_delay_line #(
    .WIDTH (SB_WIDTH),
    .DEPTH (LAT)
  ) u_sideband_dly (
    .clk  (i_sys_clk),
    .rst  (i_sys_reset),
    .din  (i_sideband),
    .dout (o_sideband)
  );

endmodule

// File: tb/tb_cog_accumulator_param.sv
// Randomized bench for cog_accumulator_param against a per-figure arithmetic model.
module tb_cog_accumulator_param;

  localparam int DW   = 8;
  localparam int CW   = 11;
  localparam int SBW  = 3;
  localparam int SWW  = 2*DW + CW;
  localparam int SWIW = 2*DW + 2*CW;
  localparam int BUSW = SWW + SWIW + 2*CW + 1;

  logic            clk = 1'b0;
  logic            rst;
  logic [DW-1:0]   image;
  logic            valid, sof, eof;
  logic [CW-1:0]   sp_in;
  logic [1:0]      mode;
  logic [DW-1:0]   bg;
  logic [CW-1:0]   mn, mx;
  logic            res_valid, ready;
  logic [SWW-1:0]  sum_w;
  logic [SWIW-1:0] sum_wi;
  logic [CW-1:0]   count, start_pt;
  logic            point_ok, overrun, abort;
  logic [SBW-1:0]  sb_in, sb_out;

  always #5 clk = ~clk;

  cog_accumulator_param #(.DATA_WIDTH(DW), .COORD_WIDTH(CW), .SB_WIDTH(SBW)) dut (
    .i_sys_clk      (clk),
    .i_sys_reset    (rst),
    .i_data_image   (image),
    .i_data_valid   (valid),
    .i_start_of_fig (sof),
    .i_end_of_fig   (eof),
    .i_start_point  (sp_in),
    .i_weight_mode  (mode),
    .i_bg_level     (bg),
    .i_min_pixels   (mn),
    .i_max_pixels   (mx),
    .o_res_valid    (res_valid),
    .i_res_ready    (ready),
    .o_sum_w        (sum_w),
    .o_sum_w_idx    (sum_wi),
    .o_pixel_count  (count),
    .o_start_point  (start_pt),
    .o_point_ok     (point_ok),
    .o_overrun      (overrun),
    .o_abort        (abort),
    .i_sideband     (sb_in),
    .o_sideband     (sb_out)
  );

  int total = 0;
  int bad   = 0;
  int pix [2200];
  longint exp_sw, exp_swi;
  int exp_cnt, exp_sp;
  bit exp_ok;

  logic [BUSW-1:0] res_bus;
  assign res_bus = {sum_w, sum_wi, count, start_pt, point_ok};

  function automatic logic [BUSW-1:0] exp_bus();
    return {SWW'(exp_sw), SWIW'(exp_swi), CW'(exp_cnt), CW'(exp_sp), exp_ok};
  endfunction

  function automatic longint wt(input int m, input int p, input int b);
    if (m == 0) return longint'(p);
    if (m == 2) return (p > b) ? longint'((p - b) * (p - b)) : 0;
    return longint'(p * p);
  endfunction

  // Only the first 2047 pixels count; anything beyond saturates the figure.
  function automatic void model(input int n, input int m, input int b, input int s,
                                input int lo, input int hi);
    longint w;
    exp_sw  = 0;
    exp_swi = 0;
    for (int i = 0; i < n && i < 2047; i++) begin
      w = wt(m, pix[i], b);
      exp_sw  += w;
      exp_swi += w * longint'(i);
    end
    exp_cnt = (n > 2047) ? 2047 : n;
    exp_sp  = s;
    exp_ok  = (n <= 2047) && (n >= lo) && (n <= hi);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; valid = 1'b0; sof = 1'b0; eof = 1'b0; ready = 1'b0; sb_in = '0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic fill_random(input int n);
    for (int i = 0; i < n; i++) pix[i] = int'($urandom_range(0, 255));
  endtask

  task automatic run_fig(input int n, input int m, input int b, input int s, input int lo,
                         input int hi, input bit close, input bit scramble);
    for (int i = 0; i < n; i++) begin
      valid = 1'b1;
      sof   = (i == 0);
      eof   = close && (i == n - 1);
      image = DW'(pix[i]);
      if (i == 0) begin
        mode = 2'(m); bg = DW'(b); sp_in = CW'(s); mn = CW'(lo); mx = CW'(hi);
      end else if (scramble) begin
        mode = 2'($urandom); bg = DW'($urandom); sp_in = CW'($urandom);
        mn = CW'($urandom); mx = CW'($urandom);
      end
      tick();
    end
    valid = 1'b0; sof = 1'b0; eof = 1'b0;
    if (close) model(n, m, b, s, lo, hi);
  endtask

  task automatic wait_res(output bit seen);
    seen = 1'b0;
    for (int k = 0; k < 12; k++) begin
      if (res_valid) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic pop();
    ready = 1'b1;
    tick();
    ready = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (res_bus !== '0) begin bad++; $display("FAIL reset_bus got=%h exp=0", res_bus); end
    total++; if ({res_valid, overrun, abort} !== 3'b000) begin
      bad++; $display("FAIL reset_flags got=%b exp=000", {res_valid, overrun, abort}); end
    total++; if (sb_out !== '0) begin bad++; $display("FAIL reset_sideband got=%b exp=0", sb_out); end
  endtask

  task automatic test_latency();
    pix[0] = 10; pix[1] = 20; pix[2] = 30;
    run_fig(3, 1, 0, 57, 0, 2047, 1'b1, 1'b0);
    total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL latency_c1 got=%b exp=0", res_valid); end
    tick();
    total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL latency_c2 got=%b exp=0", res_valid); end
    tick();
    total++; if (res_valid !== 1'b1) begin bad++; $display("FAIL latency_c3 got=%b exp=1", res_valid); end
    total++; if (res_bus !== {27'd1400, 38'd2200, 11'd3, 11'd57, 1'b1}) begin
      bad++; $display("FAIL basic_result got=%h exp=%h", res_bus, {27'd1400, 38'd2200, 11'd3, 11'd57, 1'b1}); end
    pop();
    total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL basic_pop got=%b exp=0", res_valid); end
  endtask

  task automatic test_modes();
    bit seen;
    int n, m, strays;
    for (int t = 0; t < 10; t++) begin
      if (t < 2) begin
        n = 3; pix[0] = 10; pix[1] = 20; pix[2] = 30; m = (t == 0) ? 0 : 2;
        run_fig(n, m, 15, 100 + t, 0, 2047, 1'b1, 1'b0);
      end else begin
        n = int'($urandom_range(1, 24));
        m = int'($urandom_range(0, 3));
        fill_random(n);
        strays = int'($urandom_range(0, 3));
        for (int s = 0; s < strays; s++) begin
          valid = 1'b1; sof = 1'b0; eof = 1'($urandom); image = DW'($urandom);
          tick();
        end
        run_fig(n, m, int'($urandom_range(0, 255)), int'($urandom_range(0, 2047)),
                int'($urandom_range(0, 10)), int'($urandom_range(5, 30)), 1'b1, 1'b1);
      end
      wait_res(seen);
      total++; if (!seen) begin bad++; $display("FAIL modes_timeout fig=%0d got=none exp=result", t); end
      total++; if (res_bus !== exp_bus()) begin
        bad++; $display("FAIL modes_result fig=%0d mode=%0d got=%h exp=%h", t, m, res_bus, exp_bus()); end
      pop();
    end
  endtask

  task automatic test_limits();
    int lens [5] = '{2, 3, 100, 101, 1};
    bit seen;
    for (int t = 0; t < 5; t++) begin
      fill_random(lens[t]);
      run_fig(lens[t], int'($urandom_range(0, 3)), 40, 7 * t, 3, 100, 1'b1, 1'b0);
      wait_res(seen);
      total++; if (!seen) begin bad++; $display("FAIL limits_timeout len=%0d got=none exp=result", lens[t]); end
      total++; if (res_bus !== exp_bus()) begin
        bad++; $display("FAIL limits_result len=%0d got=%h exp=%h", lens[t], res_bus, exp_bus()); end
      pop();
    end
  endtask

  task automatic test_back_to_back();
    logic [BUSW-1:0] exp_a, exp_d;
    bit seen;
    do_reset();
    fill_random(5);
    run_fig(5, 1, 0, 11, 0, 50, 1'b1, 1'b0);
    exp_a = exp_bus();
    fill_random(4);
    run_fig(4, 0, 0, 22, 0, 50, 1'b1, 1'b0);
    tick(); tick(); tick();
    total++; if ({res_valid, overrun} !== 2'b11) begin
      bad++; $display("FAIL b2b_overrun got=%b exp=11", {res_valid, overrun}); end
    total++; if (res_bus !== exp_a) begin bad++; $display("FAIL b2b_held got=%h exp=%h", res_bus, exp_a); end
    tick(); tick(); tick();
    total++; if (res_bus !== exp_a) begin bad++; $display("FAIL b2b_stable got=%h exp=%h", res_bus, exp_a); end
    pop();
    total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL b2b_accept got=%b exp=0", res_valid); end

    do_reset();
    fill_random(6);
    run_fig(6, 2, 30, 33, 0, 50, 1'b1, 1'b0);
    wait_res(seen);
    total++; if (!seen) begin bad++; $display("FAIL same_cycle_timeout got=none exp=result"); end
    fill_random(3);
    run_fig(3, 1, 0, 44, 0, 50, 1'b1, 1'b0);
    exp_d = exp_bus();
    tick();
    ready = 1'b1;
    tick();
    ready = 1'b0;
    total++; if ({res_valid, overrun} !== 2'b10) begin
      bad++; $display("FAIL same_cycle_flags got=%b exp=10", {res_valid, overrun}); end
    total++; if (res_bus !== exp_d) begin bad++; $display("FAIL same_cycle_result got=%h exp=%h", res_bus, exp_d); end
    pop();
  endtask

  task automatic test_abort();
    bit seen;
    total++; if (abort !== 1'b0) begin bad++; $display("FAIL abort_initial got=%b exp=0", abort); end
    fill_random(5);
    run_fig(5, 0, 0, 99, 0, 50, 1'b0, 1'b0);
    fill_random(7);
    run_fig(7, 1, 0, 123, 2, 9, 1'b1, 1'b0);
    wait_res(seen);
    total++; if (!seen) begin bad++; $display("FAIL abort_timeout got=none exp=result"); end
    total++; if (res_bus !== exp_bus()) begin bad++; $display("FAIL abort_result got=%h exp=%h", res_bus, exp_bus()); end
    total++; if (abort !== 1'b1) begin bad++; $display("FAIL abort_flag got=%b exp=1", abort); end
    pop();
    for (int k = 0; k < 6; k++) tick();
    total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL abort_extra got=%b exp=0", res_valid); end
    sb_in = 3'b101;
    tick();
    sb_in = 3'b000;
    for (int k = 0; k < 4; k++) begin
      total++;
      if (sb_out !== ((k == 2) ? 3'b101 : 3'b000)) begin
        bad++; $display("FAIL sideband_delay step=%0d got=%b exp=%b", k, sb_out, (k == 2) ? 3'b101 : 3'b000);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    bit seen;
    fill_random(4);
    run_fig(4, 1, 0, 5, 0, 50, 1'b1, 1'b0);
    wait_res(seen);
    sb_in = 3'b111;
    fill_random(6);
    run_fig(6, 1, 0, 6, 0, 50, 1'b0, 1'b0);
    rst = 1'b1; sb_in = '0;
    tick();
    total++; if (res_bus !== '0) begin bad++; $display("FAIL rstmid_bus got=%h exp=0", res_bus); end
    total++; if ({res_valid, overrun, abort, sb_out} !== 6'b0) begin
      bad++; $display("FAIL rstmid_flags got=%b exp=0", {res_valid, overrun, abort, sb_out}); end
    rst = 1'b0;
    fill_random(9);
    run_fig(9, 2, 60, 321, 9, 9, 1'b1, 1'b1);
    wait_res(seen);
    total++; if (!seen) begin bad++; $display("FAIL rstmid_timeout got=none exp=result"); end
    total++; if (res_bus !== exp_bus()) begin bad++; $display("FAIL rstmid_result got=%h exp=%h", res_bus, exp_bus()); end
    pop();
  endtask

  task automatic test_saturation();
    bit seen;
    fill_random(2100);
    run_fig(2100, int'($urandom_range(0, 3)), 50, 1000, 0, 2047, 1'b1, 1'b0);
    wait_res(seen);
    total++; if (!seen) begin bad++; $display("FAIL sat_timeout got=none exp=result"); end
    total++; if (res_bus !== exp_bus()) begin bad++; $display("FAIL sat_result got=%h exp=%h", res_bus, exp_bus()); end
    pop();
  endtask

  initial begin
    rst = 1'b1; image = '0; valid = 1'b0; sof = 1'b0; eof = 1'b0; sp_in = '0; mode = '0;
    bg = '0; mn = '0; mx = '0; ready = 1'b0; sb_in = '0;
    test_reset();
    test_latency();
    test_modes();
    test_limits();
    test_back_to_back();
    test_abort();
    test_reset_mid();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule
